// File: rtl/bus_term_fifo_if.sv
// Handshake bundle between a terminal transmit queue, its writing agent and the consuming bus.
// The queue side uses the slave modport; the agent/bus side uses the master modport.
interface bus_term_fifo_if #(
    parameter int pkg_sz = 16,
    parameter int depth  = 8
);
    localparam int CW = $clog2(depth) + 1;

    logic              wr_push;
    logic [pkg_sz-1:0] wr_data;
    logic              full;
    logic              wr_drop;
    logic              pop;
    logic [pkg_sz-1:0] d_out;
    logic              pndng;
    logic [CW-1:0]     count;
    logic              rd_err;

    modport master (
        output wr_push, wr_data, pop,
        input  full, wr_drop, d_out, pndng, count, rd_err
    );

    modport slave (
        input  wr_push, wr_data, pop,
        output full, wr_drop, d_out, pndng, count, rd_err
    );
endinterface

// File: rtl/bus_term_fifo.sv
// First-word-fall-through transmit queue for one bus terminal; rejects self-addressed packets.
// Optional saturating drop/pop statistics counters are enabled by defining BUS_TERM_FIFO_STATS_EN.
module bus_term_fifo #(
    parameter int         pkg_sz    = 16,
    parameter int         depth     = 8,
    parameter logic [7:0] drvr_id   = 8'h00,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                clk,
    input  logic                rst,
    bus_term_fifo_if.slave      bus
`ifdef BUS_TERM_FIFO_STATS_EN
    ,
    output logic [15:0]         drop_cnt_o,
    output logic [15:0]         pop_cnt_o
`endif
);
    localparam int            AW      = $clog2(depth);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(depth);

    logic [pkg_sz-1:0] mem [depth];

    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wrDrop_q, wrDrop_d;
    logic          rdErr_q, rdErr_d;

    logic [7:0]    dst;
    logic          addrOk;
    logic          notEmpty;
    logic          isFull;
    logic          popAcc;
    logic          pushAcc;

    assign notEmpty = (count_q != '0);
    assign isFull   = (count_q == DEPTH_C);

    // Broadcast overrides the self-address check; a full queue still takes a push if the head leaves this cycle.
    always_comb begin
        dst      = bus.wr_data[pkg_sz-1 -: 8];
        addrOk   = (dst != drvr_id) || (dst == broadcast);
        popAcc   = bus.pop && notEmpty;
        pushAcc  = bus.wr_push && addrOk && (!isFull || popAcc);
        wrDrop_d = bus.wr_push && !pushAcc;
        rdErr_d  = bus.pop && !notEmpty;

        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushAcc) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (popAcc) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        case ({pushAcc, popAcc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            wrDrop_q <= 1'b0;
            rdErr_q  <= 1'b0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            wrDrop_q <= wrDrop_d;
            rdErr_q  <= rdErr_d;
        end
    end

    // Storage contents need no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (pushAcc) begin
            mem[wrPtr_q] <= bus.wr_data;
        end
    end

    always_comb begin
        bus.d_out   = notEmpty ? mem[rdPtr_q] : '0;
        bus.pndng   = notEmpty;
        bus.full    = isFull;
        bus.count   = count_q;
        bus.wr_drop = wrDrop_q;
        bus.rd_err  = rdErr_q;
    end

`ifdef BUS_TERM_FIFO_STATS_EN
    logic [15:0] dropCnt_q;
    logic [15:0] popCnt_q;

    // Counters saturate rather than wrap so a long run never reports a misleadingly small total.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropCnt_q <= '0;
            popCnt_q  <= '0;
        end else begin
            if (wrDrop_d && (dropCnt_q != 16'hFFFF)) begin
                dropCnt_q <= dropCnt_q + 16'd1;
            end
            if (popAcc && (popCnt_q != 16'hFFFF)) begin
                popCnt_q <= popCnt_q + 16'd1;
            end
        end
    end

    assign drop_cnt_o = dropCnt_q;
    assign pop_cnt_o  = popCnt_q;
`endif
endmodule

// File: tb/tb_bus_term_fifo.sv
// Directed self-checking bench for bus_term_fifo: a vector table plus hand-written multi-cycle sequences.
module tb_bus_term_fifo;
    logic clk;
    logic rst;

    int nCompared;
    int nMismatched;

    bus_term_fifo_if #(.pkg_sz(16), .depth(8)) bus0 ();
    bus_term_fifo_if #(.pkg_sz(16), .depth(8)) bus3 ();

`ifdef BUS_TERM_FIFO_STATS_EN
    logic [15:0] dropCnt0, popCnt0, dropCnt3, popCnt3;
`endif

    bus_term_fifo #(.pkg_sz(16), .depth(8), .drvr_id(8'h00), .broadcast(8'hFF)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
`ifdef BUS_TERM_FIFO_STATS_EN
        ,
        .drop_cnt_o (dropCnt0),
        .pop_cnt_o  (popCnt0)
`endif
    );

    bus_term_fifo #(.pkg_sz(16), .depth(8), .drvr_id(8'h03), .broadcast(8'hFF)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
`ifdef BUS_TERM_FIFO_STATS_EN
        ,
        .drop_cnt_o (dropCnt3),
        .pop_cnt_o  (popCnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        push;
        logic [15:0] data;
        logic        pop;
        logic        full;
        logic        drop;
        logic        pndng;
        logic [15:0] dout;
        logic [3:0]  count;
        logic        rderr;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic full, input logic drop, input logic pndng,
                            input logic [15:0] dout, input logic [3:0] count, input logic rderr);
        checkOutput({tag, ".full"},    32'(bus0.full),    32'(full));
        checkOutput({tag, ".wr_drop"}, 32'(bus0.wr_drop), 32'(drop));
        checkOutput({tag, ".pndng"},   32'(bus0.pndng),   32'(pndng));
        checkOutput({tag, ".d_out"},   32'(bus0.d_out),   32'(dout));
        checkOutput({tag, ".count"},   32'(bus0.count),   32'(count));
        checkOutput({tag, ".rd_err"},  32'(bus0.rd_err),  32'(rderr));
    endtask

    // One clock on terminal 0: drive at negedge, sample just after the rising edge, then idle the inputs.
    task automatic applyStimulus(input logic push, input logic [15:0] data, input logic pop);
        @(negedge clk);
        bus0.wr_push = push;
        bus0.wr_data = data;
        bus0.pop     = pop;
        @(posedge clk);
        #1;
        bus0.wr_push = 1'b0;
        bus0.wr_data = 16'h0000;
        bus0.pop     = 1'b0;
    endtask

    task automatic applyStimulus3(input logic push, input logic [15:0] data, input logic pop);
        @(negedge clk);
        bus3.wr_push = push;
        bus3.wr_data = data;
        bus3.pop     = pop;
        @(posedge clk);
        #1;
        bus3.wr_push = 1'b0;
        bus3.wr_data = 16'h0000;
        bus3.pop     = 1'b0;
    endtask

    initial begin
        logic [15:0] expOrder[8];

        nCompared   = 0;
        nMismatched = 0;
        bus0.wr_push = 1'b0; bus0.wr_data = '0; bus0.pop = 1'b0;
        bus3.wr_push = 1'b0; bus3.wr_data = '0; bus3.pop = 1'b0;

        //           name          push data      pop  full drop pndng dout      cnt rderr
        vecs[0] = '{"push0312",     1, 16'h0312, 0,   0,   0,   1,    16'h0312, 1,  0};
        vecs[1] = '{"pop0312",      0, 16'h0000, 1,   0,   0,   0,    16'h0000, 0,  0};
        vecs[2] = '{"popEmpty",     0, 16'h0000, 1,   0,   0,   0,    16'h0000, 0,  1};
        vecs[3] = '{"idleAfterErr", 0, 16'h0000, 0,   0,   0,   0,    16'h0000, 0,  0};
        vecs[4] = '{"pushPopEmpty", 1, 16'h0400, 1,   0,   0,   1,    16'h0400, 1,  1};
        vecs[5] = '{"pop0400",      0, 16'h0000, 1,   0,   0,   0,    16'h0000, 0,  0};
        vecs[6] = '{"pushSelf",     1, 16'h0011, 0,   0,   1,   0,    16'h0000, 0,  0};
        vecs[7] = '{"pushBcast",    1, 16'hFF22, 0,   0,   0,   1,    16'hFF22, 1,  0};
        vecs[8] = '{"popBcast",     0, 16'h0000, 1,   0,   0,   0,    16'h0000, 0,  0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkAll("reset", 0, 0, 0, 16'h0000, 4'd0, 0);
        checkOutput("reset.t3.count", 32'(bus3.count), 32'd0);
`ifdef BUS_TERM_FIFO_STATS_EN
        checkOutput("reset.drop_cnt", 32'(dropCnt0), 32'd0);
        checkOutput("reset.pop_cnt",  32'(popCnt0),  32'd0);
`endif

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].push, vecs[i].data, vecs[i].pop);
            checkAll(vecs[i].name, vecs[i].full, vecs[i].drop, vecs[i].pndng,
                     vecs[i].dout, vecs[i].count, vecs[i].rderr);
        end

        // Fill to full, then overflow once.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b0);
            checkOutput("fill.count", 32'(bus0.count), 32'(i + 1));
            checkOutput("fill.head",  32'(bus0.d_out), 32'h0100);
        end
        checkOutput("fill.full", 32'(bus0.full), 32'd1);
        applyStimulus(1'b1, 16'h0108, 1'b0);
        checkAll("overflow", 1, 1, 1, 16'h0100, 4'd8, 0);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        checkAll("overflowIdle", 1, 0, 1, 16'h0100, 4'd8, 0);

        for (int i = 0; i < 8; i++) begin
            checkOutput("drain1.head", 32'(bus0.d_out), 32'h0100 + 32'(i));
            applyStimulus(1'b0, 16'h0000, 1'b1);
        end
        checkAll("drain1.empty", 0, 0, 0, 16'h0000, 4'd0, 0);

        // Second fill wraps the pointers; then push and pop together while full.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b0);
        end
        checkAll("refill", 1, 0, 1, 16'h0100, 4'd8, 0);
        applyStimulus(1'b1, 16'h0209, 1'b1);
        checkAll("pushPopFull", 1, 0, 1, 16'h0101, 4'd8, 0);

        for (int i = 0; i < 7; i++) expOrder[i] = 16'h0101 + 16'(i);
        expOrder[7] = 16'h0209;
        for (int i = 0; i < 8; i++) begin
            checkOutput("drain2.head", 32'(bus0.d_out), 32'(expOrder[i]));
            applyStimulus(1'b0, 16'h0000, 1'b1);
        end
        checkAll("drain2.empty", 0, 0, 0, 16'h0000, 4'd0, 0);

        // Terminal 3 rejects its own ID but accepts broadcast.
        applyStimulus3(1'b1, 16'h03AA, 1'b0);
        checkOutput("t3.self.drop",  32'(bus3.wr_drop), 32'd1);
        checkOutput("t3.self.count", 32'(bus3.count),   32'd0);
        applyStimulus3(1'b1, 16'hFF55, 1'b0);
        checkOutput("t3.bcast.drop",  32'(bus3.wr_drop), 32'd0);
        checkOutput("t3.bcast.count", 32'(bus3.count),   32'd1);
        checkOutput("t3.bcast.d_out", 32'(bus3.d_out),   32'hFF55);
        checkOutput("t3.bcast.pndng", 32'(bus3.pndng),   32'd1);

        // Asynchronous reset in the middle of a clock period with five entries held.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h0500 + 16'(i), 1'b0);
        end
        checkAll("preReset", 0, 0, 1, 16'h0500, 4'd5, 0);
        #1;
        rst = 1'b1;
        #1;
        checkAll("asyncReset", 0, 0, 0, 16'h0000, 4'd0, 0);
        checkOutput("asyncReset.t3.count", 32'(bus3.count), 32'd0);
`ifdef BUS_TERM_FIFO_STATS_EN
        checkOutput("asyncReset.drop_cnt", 32'(dropCnt0), 32'd0);
        checkOutput("asyncReset.pop_cnt",  32'(popCnt0),  32'd0);
        checkOutput("asyncReset.t3.drop_cnt", 32'(dropCnt3), 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkAll("postReset", 0, 0, 0, 16'h0000, 4'd0, 0);
        applyStimulus(1'b1, 16'h0777, 1'b0);
        checkAll("postReset.push", 0, 0, 1, 16'h0777, 4'd1, 0);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkAll("postReset.pop", 0, 0, 0, 16'h0000, 4'd0, 0);
`ifdef BUS_TERM_FIFO_STATS_EN
        checkOutput("stats.pop_cnt",  32'(popCnt0),  32'd1);
        checkOutput("stats.drop_cnt", 32'(dropCnt0), 32'd0);
        applyStimulus(1'b1, 16'h0033, 1'b0);
        checkOutput("stats.drop_cnt.self", 32'(dropCnt0), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/bus_term_fifo.md
Name: bus_term_fifo

Overview:
- Per-terminal transmit queue that sits directly upstream of the bus DUT port: the testbench agent pushes packets in, and the bus consumes them through its pop/pndng/d_out handshake.
- One instance per (bit, driver) slot; instance outputs drive the d_out/pndng array entries, and the bus pop entry drives this block's pop.
- Queue is first-word-fall-through. Packets addressed to the terminal itself are rejected at the write side.

Parameters:
- pkg_sz, 16, packet width in bits; upper 8 bits carry destination ID, must be >= 9
- depth, 8, number of entries; power of two, >= 2
- drvr_id, 0, this terminal's ID (8 bits), compared against packet destination
- broadcast, 8'hFF, destination ID meaning all terminals; always accepted

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- wr_push  input  1  agent write strobe
- wr_data  input  pkg_sz  agent packet
- full  output  1  queue holds depth entries
- wr_drop  output  1  one-cycle pulse: push rejected (full or self-addressed)
- pop  input  1  bus consumes head entry
- d_out  output  pkg_sz  head packet, valid while pndng=1
- pndng  output  1  queue non-empty
- count  output  $clog2(depth)+1  occupancy 0..depth
- rd_err  output  1  one-cycle pulse: pop while pndng=0

Behaviour:
- Reset (asynchronous assert, synchronous release at the next clk edge):
  - wr/rd pointers = 0, count = 0, full = 0, pndng = 0
  - d_out = 0, wr_drop = 0, rd_err = 0
  - stored contents are don't-care
- Storage: circular buffer of depth words. Pointers are $clog2(depth) bits and wrap naturally from depth-1 to 0.
- Write acceptance: wr_push=1 and dst=wr_data[pkg_sz-1 -: 8].
  - Accepted if dst != drvr_id, or if dst == broadcast (broadcast wins over the self-address check).
  - Also requires that the queue is not full, or that pop is accepted in the same cycle (see below).
- Rejected push: no state change except wr_drop=1 in the next cycle, for exactly one cycle.
- Pop acceptance: pop=1 and pndng=1. Advances the rd pointer.
- pop with pndng=0: ignored; rd_err=1 in the next cycle for one cycle.
- d_out/pndng (first-word-fall-through):
  - d_out always equals mem[rd_ptr] when pndng=1; d_out=0 when empty.
  - Write-to-pndng latency: 1 cycle. An accepted push into an empty queue at edge N gives pndng=1 and d_out=wr_data after edge N.
  - No same-cycle bypass.
- count: +1 on accepted push only, -1 on accepted pop only, unchanged on both or neither.
  - full = (count==depth); pndng = (count!=0). Both are registered/derived from registered count, with no combinational path from the inputs.
- Simultaneous push+pop:
  - Full queue: both accepted, count stays depth, full stays 1.
  - Empty queue: push accepted; pop rejected with rd_err.
- Reset mid-operation: all in-flight entries are discarded immediately; no pulse outputs are generated by reset.

Optional Feature:
- Macro: BUS_TERM_FIFO_STATS_EN
- Defined:
  - Adds outputs drop_cnt[15:0] and pop_cnt[15:0], both reset to 0.
  - drop_cnt increments on every wr_drop event; pop_cnt increments on every accepted pop.
  - Both saturate at 16'hFFFF, with no wrap.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then push 16'h0312 (drvr_id=0) -> next cycle pndng=1, d_out=16'h0312, count=1; pop -> next cycle pndng=0, d_out=0, count=0.
- depth=8: push 8 distinct packets 16'h0100..16'h0107 -> full=1, count=8; 9th push -> wr_drop pulses once, contents unchanged; 8 pops return 16'h0100..16'h0107 in order (covers pointer wrap after a second fill).
- drvr_id=3: push 16'h03AA -> wr_drop=1, count=0; push 16'hFF55 -> accepted, d_out=16'hFF55.
- Full queue, push 16'h0209 with pop in the same cycle -> count stays 8, full=1; the head advances and 16'h0209 emerges last.
- Empty queue, pop=1 -> rd_err pulses once, count=0; push+pop in the same cycle while empty -> count=1, rd_err=1.
- Fill 5 entries, assert rst mid-cycle asynchronously -> pndng, full and count drop to 0 before the next edge; with STATS_EN, drop_cnt and pop_cnt read 0.
